// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause/stop, one-cycle underflow pulse and auto-reload.
// Optional tick prescaler enabled by defining COUNTDOWN_PRESCALE_EN.
module countdown_timer #(
  parameter int COUNT_W    = 16
`ifdef COUNTDOWN_PRESCALE_EN
  ,parameter int PRESCALE_W = 8
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic               auto_reload,
`ifdef COUNTDOWN_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [COUNT_W-1:0] count,
  output logic               underflow,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] reload_q, reload_d;
  logic               uf_q, uf_d;
  logic               tick;

`ifdef COUNTDOWN_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  assign tick = (psc_q == prescale);
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      uf_q     <= 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
      psc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      uf_q     <= uf_d;
`ifdef COUNTDOWN_PRESCALE_EN
      psc_q    <= psc_d;
`endif
    end
  end

  // Each state resolves its inputs as stop > pause > start > load.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    uf_d     = 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
    psc_d    = psc_q;
`endif
    case (state_q)
      IDLE: begin
        if (stop || pause) begin
          state_d = IDLE;
        end else if (start) begin
          if (count_q != '0) begin
            state_d = RUN;
`ifdef COUNTDOWN_PRESCALE_EN
            psc_d   = '0;
`endif
          end
        end else if (load) begin
          count_d  = load_val;
          reload_d = load_val;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSED;
        end else begin
`ifdef COUNTDOWN_PRESCALE_EN
          psc_d = tick ? '0 : psc_q + 1'b1;
`endif
          if (tick) begin
            if (count_q == COUNT_W'(1)) begin
              uf_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else if (count_q != '0) begin
              count_d = count_q - 1'b1;
            end
          end
        end
      end
      PAUSED: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSED;
        end else if (start) begin
          state_d = RUN;
        end else if (load) begin
          count_d  = load_val;
          reload_d = load_val;
        end
      end
      default: begin // DONE
        if (stop) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = DONE;
        end else if (start) begin
          if (reload_q != '0) begin
            count_d = reload_q;
            state_d = RUN;
`ifdef COUNTDOWN_PRESCALE_EN
            psc_d   = '0;
`endif
          end
        end else if (load) begin
          count_d  = load_val;
          reload_d = load_val;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    count     = count_q;
    underflow = uf_q;
    busy      = (state_q == RUN) || (state_q == PAUSED);
    done      = (state_q == DONE);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  localparam int COUNT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load, start, pause, stop, auto_reload;
  logic [COUNT_W-1:0] load_val;
  logic [COUNT_W-1:0] count;
  logic               underflow, busy, done;
`ifdef COUNTDOWN_PRESCALE_EN
  logic [7:0]         prescale;
`endif

  int total = 0;
  int bad   = 0;

  countdown_timer #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .stop(stop), .auto_reload(auto_reload),
`ifdef COUNTDOWN_PRESCALE_EN
    .prescale(prescale),
`endif
    .count(count), .underflow(underflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input bit u, input bit b, input bit d);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".underflow"}, 32'(underflow), 32'(u));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  initial begin
    rst_n = 1'b0; load = 0; start = 0; pause = 0; stop = 0; auto_reload = 0; load_val = '0;
`ifdef COUNTDOWN_PRESCALE_EN
    prescale = '0;
`endif
    #12;
    chk_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    // start with count=0 is ignored
    start = 1; step(); start = 0;
    chk_all("start_zero", 0, 0, 0, 0);

    // one-shot countdown from 5
    load_val = 5; load = 1; step(); load = 0;
    chk_all("load5", 5, 0, 0, 0);
    start = 1; step(); start = 0;
    chk_all("start5", 5, 0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all($sformatf("run5_%0d", i), 5 - i, i == 5, i != 5, i == 5);
    end
    step(); step();
    chk_all("done_hold", 0, 0, 0, 1);

    // load from DONE returns to IDLE, then auto-reload period 3
    load_val = 3; load = 1; step(); load = 0;
    chk_all("load3", 3, 0, 0, 0);
    auto_reload = 1;
    start = 1; step(); start = 0;
    chk_all("start3", 3, 0, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk_all($sformatf("ar_%0d", k), (k % 3 == 0) ? 3 : 3 - (k % 3), k % 3 == 0, 1, 0);
    end
    stop = 1; step(); stop = 0;
    chk_all("ar_stop", 3, 0, 0, 0);
    auto_reload = 0;

    // pause/resume: underflow lands 8 cycles later than uninterrupted
    load_val = 10; load = 1; step(); load = 0;
    start = 1; step(); start = 0;
    for (int i = 1; i <= 4; i++) step();
    chk_all("pre_pause", 6, 0, 1, 0);
    pause = 1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_all($sformatf("paused_%0d", i), 6, 0, 1, 0);
    end
    pause = 0;
    start = 1; step(); start = 0;
    chk_all("resume", 6, 0, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk_all($sformatf("post_%0d", i), 6 - i, i == 6, i != 6, i == 6);
    end

    // stop+pause together, resume from held value, load ignored in RUN
    load_val = 8; load = 1; step(); load = 0;
    start = 1; step(); start = 0;
    step(); step();
    chk_all("sp_run", 6, 0, 1, 0);
    stop = 1; pause = 1; step(); stop = 0; pause = 0;
    chk_all("sp_idle", 6, 0, 0, 0);
    start = 1; step(); start = 0;
    chk_all("sp_resume", 6, 0, 1, 0);
    step();
    chk_all("sp_dec", 5, 0, 1, 0);
    load_val = 99; load = 1; step(); load = 0;
    chk_all("load_in_run", 4, 0, 1, 0);

    // asynchronous reset mid-count
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    step();
    chk_all("rst_hold", 0, 0, 0, 0);
    rst_n = 1'b1;
    step();

`ifdef COUNTDOWN_PRESCALE_EN
    prescale = 3;
    load_val = 2; load = 1; step(); load = 0;
    start = 1; step(); start = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_all($sformatf("psc_%0d", i), (i < 4) ? 2 : (i < 8) ? 1 : 0, i == 8, i != 8, i == 8);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter/timer with start, pause, stop and optional auto-reload. It counts a programmed number of ticks down to zero and reports the terminal event as a one-cycle `underflow` pulse. It is the count-down counterpart to the free-running up-counter with `overflow`, and it provides the delay and period generation used by control logic in the same clock domain.

## Interface
- `COUNT_W`, 16, width of the count, load value and reload register
- `PRESCALE_W`, 8, prescaler width; used only when `COUNTDOWN_PRESCALE_EN` is defined
- `clk`  input  1  system clock, rising edge
- `rst_n`  input  1  reset, asynchronous and active-low
- `load`  input  1  level-sampled; loads `load_val` into the count and reload registers
- `load_val`  input  COUNT_W  value to load
- `start`  input  1  start or resume counting
- `pause`  input  1  freeze the count
- `stop`  input  1  abort to IDLE; the count is held
- `auto_reload`  input  1  when 1, a terminal tick reloads and the timer keeps running
- `prescale`  input  PRESCALE_W  tick divider; present only with `COUNTDOWN_PRESCALE_EN`
- `count`  output  COUNT_W  current count, registered
- `underflow`  output  1  one-cycle pulse on each terminal tick, registered
- `busy`  output  1  high in RUN or PAUSED
- `done`  output  1  high while in DONE

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Reset values: state IDLE, `count`=0, reload register=0, prescaler=0, `underflow`=0, `busy`=0, `done`=0.
- Input priority at each edge: `stop` > `pause` > `start` > `load`.
- `stop`:
  - From any state, go to IDLE.
  - `count` and the reload register are unchanged.
  - No decrement on that edge.
- `pause`: RUN → PAUSED, with no decrement on that edge. Ignored in every other state.
- `start`:
  - IDLE: go to RUN if `count`≠0; ignored if `count`=0.
  - PAUSED: go to RUN; `count` and prescaler are kept.
  - DONE: `count` ← reload register and go to RUN if the reload register ≠0. Ignored otherwise.
  - RUN: no effect.
- `load`:
  - IDLE, PAUSED, DONE: `count` ← `load_val` and reload register ← `load_val`.
  - DONE additionally goes to IDLE.
  - RUN: ignored.
- RUN, on each tick:
  - If `count`>1: `count` ← `count`−1.
  - If `count`=1 (terminal tick):
    - `underflow`=1 for exactly one cycle.
    - If `auto_reload`=1: `count` ← reload register and stay in RUN.
    - Otherwise: `count` ← 0 and go to DONE.
- Reload register = 1 with `auto_reload`=1 gives an `underflow` pulse on every tick.
- The count never wraps below 0. RUN is never entered with `count`=0.
- `busy` and `done` are decoded from the registered state. They carry no combinational path from the inputs.

## Timing
- Without prescale, a tick is every clock edge in RUN.
- Example: `count`=N, `start` sampled at edge 0.
  - State is RUN after edge 0; `busy`=1 from that point.
  - `count`=N−1 after edge 1.
  - `underflow`=1 and `count`=0 after edge N.
  - `done`=1 after edge N, and stays high until `start`, `load` or `stop`.
- Auto-reload with reload value R: `underflow` pulses every R ticks. There is no dead cycle between periods.
- Pause/resume adds exactly the paused cycles plus the resume edge; no tick is lost or duplicated.
- Reset asserted mid-count returns all outputs to their reset values immediately and asynchronously.

## Configuration
- Macro: `COUNTDOWN_PRESCALE_EN`.
- Defined:
  - Adds the `prescale` port and a `PRESCALE_W`-bit prescaler.
  - The prescaler clears on entry to RUN from IDLE or DONE and holds in PAUSED.
  - A tick occurs when prescaler = `prescale`; the prescaler then clears, otherwise it increments.
  - One tick per `prescale`+1 clocks. `prescale` is sampled live.
- Undefined: no port and no prescaler logic; one tick per clock in RUN.

## Test plan
- Reset with `rst_n`=0 mid-RUN → `count`=0, `underflow`=0, `busy`=0, `done`=0 immediately; state IDLE.
- `load_val`=5, `load`, then `start` → `count` 4,3,2,1,0 on the next 5 edges; `underflow` high only in the cycle `count`=0; `done`=1 and stays 1.
- `load_val`=3, `auto_reload`=1, `start` → `underflow` pulses every 3 cycles for 4 periods; `count` sequence 2,1,3,2,1,3…; `done` stays 0.
- `load_val`=10, `start`, `pause` after 4 edges for 7 cycles, then `start` → `count` holds at 6 while paused; `underflow` is delayed by exactly 8 cycles compared with an uninterrupted run.
- `stop` and `pause` in the same cycle during RUN → IDLE and `count` held; a following `start` resumes from the held value. `load` during RUN → ignored.
- With `COUNTDOWN_PRESCALE_EN`, `prescale`=3, `load_val`=2 → `count` decrements every 4 clocks; `underflow` 8 clocks after the `start` edge.
